// File: rtl/decode_execute_pipe.sv
// decode_execute_pipe: two-stage decode/execute unit.
// Stage D buffers one instruction word; stage E holds the registered ALU
// result. The register file is read combinationally from D and written on
// the same edge that moves the instruction into E, so dependent
// back-to-back instructions need no forwarding.
module decode_execute_pipe #(
  parameter int N    = 32,
  parameter int REGS = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  opcode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [4:0]   rd_out,
  output logic         illegal
);

  localparam int SHW = $clog2(N);
  localparam int IW  = (REGS > 1) ? $clog2(REGS) : 1;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_ADDI = 4'd8,
    OP_SLT  = 4'd9
  } op_e;

  // Stage D and stage E state
  logic         r_d_valid;
  logic [31:0]  r_d_op;
  logic         r_e_valid;
  logic [N-1:0] r_result;
  logic [4:0]   r_rd;
  logic         r_illegal;
  logic [N-1:0] r_regs [REGS];

  // Decoded fields of the instruction sitting in D
  logic [3:0]   w_op;
  logic [4:0]   w_rd;
  logic [4:0]   w_rs1;
  logic [4:0]   w_rs2;
  logic [12:0]  w_imm13;
  logic [N-1:0] w_imm;
  logic [N-1:0] w_a;
  logic [N-1:0] w_b;
  logic [N-1:0] w_alu;
  logic         w_illegal;
  logic         w_e_adv;
  logic         w_d_load;
  logic         w_wr_en;

  assign w_op    = r_d_op[31:28];
  assign w_rd    = r_d_op[27:23];
  assign w_rs1   = r_d_op[22:18];
  assign w_rs2   = r_d_op[17:13];
  assign w_imm13 = r_d_op[12:0];
  // Sign-extend (or truncate when N < 13) the immediate to the datapath width.
  assign w_imm   = N'($signed(w_imm13));

  assign w_e_adv  = r_d_valid && (!r_e_valid || out_ready);
  assign in_ready = !r_d_valid || w_e_adv;
  assign w_d_load = in_valid && in_ready;

  // Operand read: r0 and out-of-range indices read as zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_a = '0;
    w_b = '0;
    if (w_rs1 != 5'd0 && int'(w_rs1) < REGS) w_a = r_regs[w_rs1[IW-1:0]];
    if (w_rs2 != 5'd0 && int'(w_rs2) < REGS) w_b = r_regs[w_rs2[IW-1:0]];
  end

  // ALU: modulo-2^N arithmetic; undefined ops yield 0 and flag illegal.
  always_comb begin
    w_alu     = '0;
    w_illegal = 1'b0;
    case (w_op)
      OP_NOP:  w_alu = '0;
      OP_ADD:  w_alu = w_a + w_b;
      OP_SUB:  w_alu = w_a - w_b;
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      OP_SHL:  w_alu = w_a << w_b[SHW-1:0];
      OP_SHR:  w_alu = w_a >> w_b[SHW-1:0];
      OP_ADDI: w_alu = w_a + w_imm;
      OP_SLT:  w_alu = ($signed(w_a) < $signed(w_b)) ? N'(1) : '0;
      default: w_illegal = 1'b1;
    endcase
  end

  // Writeback only for defined, value-producing ops to an existing non-zero register.
  assign w_wr_en = w_e_adv && (w_op != OP_NOP) && !w_illegal &&
                   (w_rd != 5'd0) && (int'(w_rd) < REGS);

  // Register file write, committed on the edge the instruction enters E.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is architecturally visible state, so it is cleared on reset like any other register.
      for (int i = 0; i < REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[w_rd[IW-1:0]] <= w_alu;
    end
  end

  // Pipeline registers: D loads on handshake, E loads on advance or drains on out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d_valid <= 1'b0;
      r_d_op    <= '0;
      r_e_valid <= 1'b0;
      r_result  <= '0;
      r_rd      <= '0;
      r_illegal <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, letting D and E update in the same cycle.
      if (w_d_load) begin
        r_d_valid <= 1'b1;
        r_d_op    <= opcode;
      end else if (w_e_adv) begin
        r_d_valid <= 1'b0;
      end
      if (w_e_adv) begin
        r_e_valid <= 1'b1;
        r_result  <= w_alu;
        r_rd      <= w_rd;
        r_illegal <= w_illegal;
      end else if (out_ready) begin
        r_e_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_e_valid;
  assign result    = r_result;
  assign rd_out    = r_rd;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Directed bench for decode_execute_pipe. Three instances share one stimulus
// stream: a (N=32, REGS=32), b (N=8, REGS=32), c (N=32, REGS=4).
module tb_decode_execute_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] opcode;
  logic        out_ready;

  logic        in_ready_a, in_ready_b, in_ready_c;
  logic        out_valid_a, out_valid_b, out_valid_c;
  logic [31:0] result_a;
  logic [7:0]  result_b;
  logic [31:0] result_c;
  logic [4:0]  rd_a, rd_b, rd_c;
  logic        ill_a, ill_b, ill_c;

  int checks   = 0;
  int failures = 0;

  // Expected-result table consumed by run_seq
  logic [31:0] q_op[$];
  logic [31:0] q_ea[$];
  logic [7:0]  q_eb[$];
  logic [31:0] q_ec[$];
  logic [4:0]  q_rd[$];
  logic        q_ill[$];

  decode_execute_pipe #(.N(32), .REGS(32)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .opcode(opcode), .out_valid(out_valid_a), .out_ready(out_ready),
    .result(result_a), .rd_out(rd_a), .illegal(ill_a));

  decode_execute_pipe #(.N(8), .REGS(32)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .opcode(opcode), .out_valid(out_valid_b), .out_ready(out_ready),
    .result(result_b), .rd_out(rd_b), .illegal(ill_b));

  decode_execute_pipe #(.N(32), .REGS(4)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
    .opcode(opcode), .out_valid(out_valid_c), .out_ready(out_ready),
    .result(result_c), .rd_out(rd_c), .illegal(ill_c));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs1,
                                      input int rs2, input int imm);
    return {op[3:0], rd[4:0], rs1[4:0], rs2[4:0], imm[12:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] op);
    in_valid = v;
    opcode   = op;
  endtask

  task automatic add(input logic [31:0] op, input logic [31:0] ea, input logic [7:0] eb,
                     input logic [31:0] ec, input logic [4:0] rd, input logic ill);
    q_op.push_back(op);
    q_ea.push_back(ea);
    q_eb.push_back(eb);
    q_ec.push_back(ec);
    q_rd.push_back(rd);
    q_ill.push_back(ill);
  endtask

  // Issue the queued instructions back-to-back with out_ready high and check
  // each result one cycle after the instruction is accepted.
  task automatic run_seq(input string name);
    int n;
    int j;
    n = q_op.size();
    out_ready = 1'b1;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        drive(1'b1, q_op[i]);
        check($sformatf("%s[%0d].in_ready", name, i), 64'(in_ready_a), 64'd1);
      end else begin
        drive(1'b0, 32'h0);
      end
      tick();
      if (i > 0) begin
        j = i - 1;
        check($sformatf("%s[%0d].valid", name, j), 64'(out_valid_a), 64'd1);
        check($sformatf("%s[%0d].res_a", name, j), 64'(result_a), 64'(q_ea[j]));
        check($sformatf("%s[%0d].res_b", name, j), 64'(result_b), 64'(q_eb[j]));
        check($sformatf("%s[%0d].res_c", name, j), 64'(result_c), 64'(q_ec[j]));
        check($sformatf("%s[%0d].rd", name, j), 64'(rd_a), 64'(q_rd[j]));
        check($sformatf("%s[%0d].ill_a", name, j), 64'(ill_a), 64'(q_ill[j]));
        check($sformatf("%s[%0d].ill_b", name, j), 64'(ill_b), 64'(q_ill[j]));
      end
    end
    tick();
    check($sformatf("%s.drained", name), 64'(out_valid_a), 64'd0);
    q_op.delete();
    q_ea.delete();
    q_eb.delete();
    q_ec.delete();
    q_rd.delete();
    q_ill.delete();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    opcode    = '0;
    out_ready = 1'b1;
    repeat (2) tick();

    // Reset state
    check("rst.out_valid", 64'(out_valid_a), 64'd0);
    check("rst.result", 64'(result_a), 64'd0);
    check("rst.rd_out", 64'(rd_a), 64'd0);
    check("rst.illegal", 64'(ill_a), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst.in_ready_a", 64'(in_ready_a), 64'd1);
    check("post_rst.in_ready_b", 64'(in_ready_b), 64'd1);
    check("post_rst.in_ready_c", 64'(in_ready_c), 64'd1);
    tick();
    check("idle.out_valid", 64'(out_valid_a), 64'd0);

    // Dependent back-to-back: ADDI r1=5, ADDI r2=-3, ADD r3=r1+r2
    add(enc(8, 1, 0, 0, 5),  32'd5,        8'd5,    32'd5,        5'd1, 1'b0);
    add(enc(8, 2, 0, 0, -3), 32'hFFFFFFFD, 8'hFD,   32'hFFFFFFFD, 5'd2, 1'b0);
    add(enc(1, 3, 1, 2, 0),  32'd2,        8'd2,    32'd2,        5'd3, 1'b0);
    run_seq("dep");

    // ALU ops, narrow width wrap, immediate truncation, shift-amount masking
    add(enc(8, 1, 0, 0, 1),      32'd1,        8'h01, 32'd1,        5'd1, 1'b0);
    add(enc(2, 2, 0, 1, 0),      32'hFFFFFFFF, 8'hFF, 32'hFFFFFFFF, 5'd2, 1'b0);
    add(enc(6, 3, 1, 1, 0),      32'd2,        8'h02, 32'd2,        5'd3, 1'b0);
    add(enc(7, 4, 2, 1, 0),      32'h7FFFFFFF, 8'h7F, 32'h7FFFFFFF, 5'd4, 1'b0);
    add(enc(9, 5, 2, 1, 0),      32'd1,        8'h01, 32'd1,        5'd5, 1'b0);
    add(enc(8, 6, 0, 0, 'h0FFF), 32'h00000FFF, 8'hFF, 32'h00000FFF, 5'd6, 1'b0);
    add(enc(8, 7, 0, 0, 9),      32'd9,        8'h09, 32'd9,        5'd7, 1'b0);
    add(enc(6, 8, 1, 7, 0),      32'h200,      8'h02, 32'd1,        5'd8, 1'b0);
    run_seq("alu");

    // Backpressure: 4 stalled cycles, 3 opcodes offered
    out_ready = 1'b0;
    drive(1'b1, enc(8, 9, 0, 0, 11));
    tick();
    check("bp.p1_in_d.valid", 64'(out_valid_a), 64'd0);
    check("bp.p1_in_d.in_ready", 64'(in_ready_a), 64'd1);
    drive(1'b1, enc(8, 10, 0, 0, 12));
    tick();
    check("bp.e_full.valid", 64'(out_valid_a), 64'd1);
    check("bp.e_full.result", 64'(result_a), 64'd11);
    check("bp.full.in_ready", 64'(in_ready_a), 64'd0);
    drive(1'b1, enc(8, 11, 0, 0, 13));
    tick();
    check("bp.hold1.result", 64'(result_a), 64'd11);
    check("bp.hold1.in_ready", 64'(in_ready_a), 64'd0);
    tick();
    check("bp.hold2.result", 64'(result_a), 64'd11);
    check("bp.hold2.rd", 64'(rd_a), 64'd9);
    check("bp.hold2.valid", 64'(out_valid_a), 64'd1);
    out_ready = 1'b1;
    #1;
    check("bp.release.in_ready", 64'(in_ready_a), 64'd1);
    tick();
    drive(1'b0, 32'h0);
    check("bp.p2.result", 64'(result_a), 64'd12);
    check("bp.p2.rd", 64'(rd_a), 64'd10);
    check("bp.p2.result_b", 64'(result_b), 64'd12);
    tick();
    check("bp.p3.result", 64'(result_a), 64'd13);
    check("bp.p3.rd", 64'(rd_a), 64'd11);
    check("bp.p3.valid", 64'(out_valid_a), 64'd1);
    tick();
    check("bp.drained", 64'(out_valid_a), 64'd0);

    // Illegal ops 12 and 15 do not write their rd
    add(enc(8, 12, 0, 0, 33), 32'd33, 8'd33, 32'd33, 5'd12, 1'b0);
    add(enc(12, 12, 1, 1, 0), 32'd0,  8'd0,  32'd0,  5'd12, 1'b1);
    add(enc(1, 13, 12, 0, 0), 32'd33, 8'd33, 32'd0,  5'd13, 1'b0);
    add(enc(15, 13, 1, 2, 7), 32'd0,  8'd0,  32'd0,  5'd13, 1'b1);
    add(enc(1, 14, 13, 0, 0), 32'd33, 8'd33, 32'd0,  5'd14, 1'b0);
    add(enc(0, 0, 0, 0, 0),   32'd0,  8'd0,  32'd0,  5'd0,  1'b0);
    run_seq("illegal");

    // r0 is hardwired; REGS=4 drops r5 write and reads r5 as 0
    add(enc(8, 0, 0, 0, 7), 32'd7, 8'd7, 32'd7, 5'd0, 1'b0);
    add(enc(1, 4, 0, 0, 0), 32'd0, 8'd0, 32'd0, 5'd4, 1'b0);
    add(enc(8, 5, 0, 0, 9), 32'd9, 8'd9, 32'd9, 5'd5, 1'b0);
    add(enc(1, 6, 5, 0, 0), 32'd9, 8'd9, 32'd0, 5'd6, 1'b0);
    run_seq("r0_range");

    // Reset while E is stalled holding ADDI r1 and D holds ADDI r3
    out_ready = 1'b0;
    drive(1'b1, enc(8, 1, 0, 0, 42));
    tick();
    drive(1'b1, enc(8, 3, 0, 0, 77));
    tick();
    drive(1'b0, 32'h0);
    check("mid_rst.pre.result", 64'(result_a), 64'd42);
    check("mid_rst.pre.valid", 64'(out_valid_a), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst.valid", 64'(out_valid_a), 64'd0);
    check("mid_rst.result", 64'(result_a), 64'd0);
    check("mid_rst.rd", 64'(rd_a), 64'd0);
    check("mid_rst.valid_b", 64'(out_valid_b), 64'd0);
    check("mid_rst.valid_c", 64'(out_valid_c), 64'd0);
    check("mid_rst.rd_b", 64'(rd_b), 64'd0);
    check("mid_rst.rd_c", 64'(rd_c), 64'd0);
    check("mid_rst.ill_c", 64'(ill_c), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst.after.in_ready", 64'(in_ready_a), 64'd1);
    out_ready = 1'b1;
    tick();
    check("mid_rst.discarded", 64'(out_valid_a), 64'd0);
    add(enc(1, 2, 1, 0, 0), 32'd0, 8'd0, 32'd0, 5'd2, 1'b0);
    add(enc(1, 4, 3, 0, 0), 32'd0, 8'd0, 32'd0, 5'd4, 1'b0);
    run_seq("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
